wb_regfile: RTL

Write-back stage and architectural register file of the five-stage pipeline. Consumes the registered MEM/WB control and data fields and selects the write-back value (memory load or ALU result). Commits that value into a 32 x 32-bit register file with $0 hardwired to zero. Serves two combinational read ports to the ID stage, and exports the selected write-back value for the forwarding unit.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/wb_sel.sv | 25 ++
 rtl/wb_regfile.sv | 88 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants (data/address widths, register count).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/wb_sel.sv
// Write-back mux: picks load data or ALU result, and qualifies the write strobe.
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows the MEM/WB fields every cycle.
module wb_sel
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
) (
    input  logic          MemtoReg,
    input  logic          RegWrite,
    input  logic [DW-1:0] MemOut,
    input  logic [DW-1:0] AluOut,
    input  logic [AW-1:0] Addr,
    output logic [DW-1:0] wb_data,
    output logic          wb_we
);

    // Select the retiring value; writes to $0 never strobe.
    always_comb begin
        wb_data = MemtoReg ? MemOut : AluOut;
        wb_we   = RegWrite && (Addr != AW'(REG_ZERO));
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 32x32 architectural register file ($0 reads zero), commit counter.
// Latency: writes commit at the posedge; reads and wb_data are combinational.
// Backpressure: none; MEM/WB presents RegWrite=0 on bubbles. Build option: WB_REGFILE_BYPASS_EN.
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          MemtoReg,
    input  logic          RegWrite,
    input  logic [DW-1:0] MemOut,
    input  logic [DW-1:0] AluOut,
    input  logic [AW-1:0] Addr,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic [DW-1:0] wb_data,
    output logic          wb_we,
    output logic [31:0]   wb_count
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] regs_q [DEPTH];
    logic [DW-1:0] regs_d [DEPTH];
    logic [31:0]   wb_count_q;
    logic [31:0]   wb_count_d;

    wb_sel #(.DW(DW), .AW(AW)) u_wb_sel (
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .MemOut   (MemOut),
        .AluOut   (AluOut),
        .Addr     (Addr),
        .wb_data  (wb_data),
        .wb_we    (wb_we)
    );

    // Next array contents and commit count; $0 is never targeted because wb_we excludes it.
    always_comb begin
        regs_d     = regs_q;
        wb_count_d = wb_count_q;
        if (wb_we) begin
            regs_d[Addr] = wb_data;
            wb_count_d   = wb_count_q + 32'd1;
        end
    end

    // Architectural state; asynchronous clear of the whole array and the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Read ports: $0 forced to zero; optional write-through of the retiring value.
    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
`ifdef WB_REGFILE_BYPASS_EN
        if (wb_we && (rs_addr == Addr)) begin
            rs_data = wb_data;
        end
        if (wb_we && (rt_addr == Addr)) begin
            rt_data = wb_data;
        end
`endif
        if (rs_addr == AW'(REG_ZERO)) begin
            rs_data = '0;
        end
        if (rt_addr == AW'(REG_ZERO)) begin
            rt_data = '0;
        end
    end

    assign wb_count = wb_count_q;

endmodule
